// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin burst arbiter and sequencer for a shared D-register
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   req    per-requester write request (bit i = requester i)
//   d      flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    registered one-hot grant, zero when idle
//   owner  index of the granted requester, zero when idle
//   busy   any grant active
//   wr     pulse, high the cycle after a write to q
//   q      shared register value
//   qbar   complement of q
module dff_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] d,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [OW-1:0]            owner,
  output logic                     busy,
  output logic                     wr,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_owner_q, last_owner_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               wr_q, wr_d;
  logic [OW:0]        pk;

  logic [WIDTH-1:0] d_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign d_arr[g] = d[g*WIDTH +: WIDTH];
  end

  // Returns {found, index}: first requester at or after start (mod NUM_REQ).
  // Scanning from the far end down lets the lowest offset overwrite the result.
  function automatic logic [OW:0] pick(input logic [NUM_REQ-1:0] r, input int start);
    logic [OW:0]   res;
    logic [OW-1:0] jj;
    int            j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j  = (start + k) % NUM_REQ;
      jj = j[OW-1:0];
      if (r[jj]) res = {1'b1, jj};
    end
    return res;
  endfunction

  always_comb begin
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    data_d       = data_q;
    wr_d         = 1'b0;
    pk           = '0;

    if (gnt_q == '0) begin
      pk = pick(req, int'(last_owner_q) + 1);
      if (pk[OW]) begin
        gnt_d          = '0;
        gnt_d[pk[OW-1:0]] = 1'b1;
        owner_d        = pk[OW-1:0];
        burst_cnt_d    = '0;
      end
    end else begin
      // Hand over when the owner finishes its burst or lets go early.
      // The owner is rescanned last, so it keeps the register only when
      // nobody else is waiting.
      if (req[owner_q] && (burst_cnt_q != CW'(MAX_BURST - 1))) begin
        data_d      = d_arr[owner_q];
        wr_d        = 1'b1;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        if (req[owner_q]) begin
          data_d = d_arr[owner_q];
          wr_d   = 1'b1;
        end
        last_owner_d = owner_q;
        burst_cnt_d  = '0;
        pk           = pick(req, int'(owner_q) + 1);
        gnt_d        = '0;
        if (pk[OW]) begin
          gnt_d[pk[OW-1:0]] = 1'b1;
          owner_d           = pk[OW-1:0];
        end else begin
          owner_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = |gnt_q;
  assign wr    = wr_q;
  assign q     = data_q;
  assign qbar  = ~data_q;

endmodule
